// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the CPU-side SRAM bus: arbiter FSM states, transaction
// owner and access size codes (the size codes are also used by the MEM stage).
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_req_pick.sv
// Two-way request picker: fixed data-over-inst priority, or alternation on
// contention (the requester that did not win last time goes first).
module sram_req_pick
    import cpu_bus_pkg::*;
#(
    parameter int FAIR = 0
) (
    input  logic i_inst_req,
    input  logic i_data_req,
    input  logic i_last_grant,
    output logic o_grant_inst,
    output logic o_grant_data
);

    always_comb begin
        o_grant_inst = 1'b0;
        o_grant_data = 1'b0;
        if (i_inst_req && i_data_req) begin
            if ((FAIR != 0) && (i_last_grant == OWN_DATA)) begin
                o_grant_inst = 1'b1;
            end else begin
                o_grant_data = 1'b1;
            end
        end else begin
            o_grant_inst = i_inst_req;
            o_grant_data = i_data_req;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between instruction fetch and the MEM-stage data
// port: one transaction at a time, response routed back to its owner.
module sram_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int FAIR   = 0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_inst_req,
    input  logic [ADDR_W-1:0]     i_inst_addr,
    input  logic                  i_inst_cancel,
    output logic                  o_inst_addr_ok,
    output logic                  o_inst_data_ok,
    output logic [DATA_W-1:0]     o_inst_rdata,
    input  logic                  i_data_req,
    input  logic                  i_data_wr,
    input  logic [1:0]            i_data_size,
    input  logic [ADDR_W-1:0]     i_data_addr,
    input  logic [DATA_W/8-1:0]   i_data_wstrb,
    input  logic [DATA_W-1:0]     i_data_wdata,
    output logic                  o_data_addr_ok,
    output logic                  o_data_data_ok,
    output logic [DATA_W-1:0]     o_data_rdata,
    output logic                  o_mem_req,
    output logic                  o_mem_wr,
    output logic [1:0]            o_mem_size,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W/8-1:0]   o_mem_wstrb,
    output logic [DATA_W-1:0]     o_mem_wdata,
    input  logic                  i_mem_addr_ok,
    input  logic                  i_mem_data_ok,
    input  logic [DATA_W-1:0]     i_mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_e          r_state;
    arb_state_e          w_next_state;
    owner_e              r_owner;
    owner_e              r_last_grant;
    logic                r_cancel;
    logic                r_mem_req;
    logic                r_mem_wr;
    logic [1:0]          r_mem_size;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [STRB_W-1:0]   r_mem_wstrb;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic w_inst_elig;
    logic w_grant_inst;
    logic w_grant_data;
    logic w_granted;
    logic w_resp;
    logic w_swallow;

    assign w_inst_elig = i_inst_req & ~i_inst_cancel;

    sram_req_pick #(
        .FAIR(FAIR)
    ) u_pick (
        .i_inst_req  (w_inst_elig),
        .i_data_req  (i_data_req),
        .i_last_grant(r_last_grant),
        .o_grant_inst(w_grant_inst),
        .o_grant_data(w_grant_data)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A zero-latency slave completes in ADDR, so the response can come from either ADDR or WAIT.
    always_comb begin
        w_next_state   = r_state;
        w_granted      = 1'b0;
        w_resp         = 1'b0;
        o_inst_addr_ok = 1'b0;
        o_data_addr_ok = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_granted      = w_grant_inst | w_grant_data;
                o_inst_addr_ok = w_grant_inst;
                o_data_addr_ok = w_grant_data;
                if (w_granted) begin
                    w_next_state = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (i_mem_addr_ok) begin
                    w_resp       = i_mem_data_ok;
                    w_next_state = i_mem_data_ok ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_mem_data_ok) begin
                    w_resp       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_owner      <= OWN_INST;
            r_last_grant <= OWN_INST;
            r_cancel     <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_size   <= 2'd0;
            r_mem_addr   <= '0;
            r_mem_wstrb  <= '0;
            r_mem_wdata  <= '0;
        end else begin
            if (w_granted) begin
                r_mem_req    <= 1'b1;
                r_owner      <= w_grant_data ? OWN_DATA : OWN_INST;
                r_last_grant <= w_grant_data ? OWN_DATA : OWN_INST;
                if (w_grant_data) begin
                    r_mem_wr    <= i_data_wr;
                    r_mem_size  <= i_data_size;
                    r_mem_addr  <= i_data_addr;
                    r_mem_wstrb <= i_data_wstrb;
                    r_mem_wdata <= i_data_wdata;
                end else begin
                    r_mem_wr    <= 1'b0;
                    r_mem_size  <= SZ_WORD;
                    r_mem_addr  <= i_inst_addr;
                    r_mem_wstrb <= '0;
                    r_mem_wdata <= '0;
                end
            end else if ((r_state == ST_ADDR) && i_mem_addr_ok) begin
                r_mem_req <= 1'b0;
            end
            if (w_resp) begin
                r_cancel <= 1'b0;
            end else if (((r_state == ST_ADDR) || (r_state == ST_WAIT)) &&
                         (r_owner == OWN_INST) && i_inst_cancel) begin
                r_cancel <= 1'b1;
            end
        end
    end

    // A flush arriving in the same cycle as the response swallows it as well.
    assign w_swallow      = (r_owner == OWN_INST) & (r_cancel | i_inst_cancel);
    assign o_inst_data_ok = w_resp & (r_owner == OWN_INST) & ~w_swallow;
    assign o_data_data_ok = w_resp & (r_owner == OWN_DATA);
    assign o_inst_rdata   = o_inst_data_ok ? i_mem_rdata : '0;
    assign o_data_rdata   = o_data_data_ok ? i_mem_rdata : '0;

    assign o_mem_req   = r_mem_req;
    assign o_mem_wr    = r_mem_wr;
    assign o_mem_size  = r_mem_size;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wstrb = r_mem_wstrb;
    assign o_mem_wdata = r_mem_wdata;

endmodule
